// File: rtl/traffic_conflict_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Lamp codes, monitor states and fault codes shared by the
//               traffic conflict monitor files.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_ALL = 3'b111;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        PASS    = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_INV   = 2'b01;
    localparam logic [1:0] FC_MULTI = 2'b10;

    function automatic logic lamp_code_valid(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_conflict_monitor_if
// Description : Controller-to-monitor lamp bus. Carries lamp_test only when
//               TRAFFIC_LAMP_TEST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_conflict_monitor_if;

    logic [2:0] d1_in;
    logic [2:0] d2_in;
    logic [2:0] d3_in;
    logic [2:0] d4_in;
    logic       fault_clear;
`ifdef TRAFFIC_LAMP_TEST_EN
    logic       lamp_test;
`endif
    logic [2:0] lamp1;
    logic [2:0] lamp2;
    logic [2:0] lamp3;
    logic [2:0] lamp4;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
`ifdef TRAFFIC_LAMP_TEST_EN
        output lamp_test,
`endif
        output d1_in, d2_in, d3_in, d4_in, fault_clear,
        input  lamp1, lamp2, lamp3, lamp4, fault, fault_code
    );

    modport slave (
`ifdef TRAFFIC_LAMP_TEST_EN
        input  lamp_test,
`endif
        input  d1_in, d2_in, d3_in, d4_in, fault_clear,
        output lamp1, lamp2, lamp3, lamp4, fault, fault_code
    );

endinterface
`default_nettype wire

// File: rtl/traffic_conflict_monitor_flash_gen.sv
`default_nettype none
// ============================================================================
// Module      : flash_gen
// Description : Half-period counter producing a flash phase bit (1 = on).
// Revision    : 1.0 - initial release
// ============================================================================
module flash_gen #(
    parameter int HALF = 25000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      phase,
    output logic      last
);

    localparam int              c_cnt_w    = $clog2(HALF + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HALF - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_phase;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (enable) begin
            if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // 'last' lets the parent register the phase that the next cycle will show.
    assign last  = (r_cnt == c_cnt_last);
    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_conflict_monitor
// Description : Registers lamp codes to the lamp drivers, latching a flashing
//               yellow fault on persistent conflicts. TRAFFIC_LAMP_TEST_EN
//               adds a lamp_test override.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FLASH_HALF     = 25000000,
    parameter int DEBOUNCE       = 4,
    parameter int STARTUP_CYCLES = 50000000
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    traffic_conflict_monitor_if.slave bus
);

    localparam int                  c_step_w    = $clog2(STARTUP_CYCLES + 1);
    localparam int                  c_deb_w     = $clog2(DEBOUNCE + 1);
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STARTUP_CYCLES - 1);
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE - 1);

    state_t              r_state;
    logic [c_step_w-1:0] r_step;
    logic [c_deb_w-1:0]  r_deb;
    logic [3:0][2:0]     r_lamp;
    logic                r_fault;
    logic [1:0]          r_fc;

    logic [3:0][2:0] w_d;
    logic [2:0]      w_nonred;
    logic            w_inv;
    logic            w_multi;
    logic            w_conflict;
    logic            w_in_fault;
    logic            w_phase;
    logic            w_last;
    logic [2:0]      w_flash_lamp;

    assign w_d = {bus.d4_in, bus.d3_in, bus.d2_in, bus.d1_in};

    always_comb begin
        w_inv    = 1'b0;
        w_nonred = '0;
        for (int i = 0; i < 4; i++) begin
            if (!lamp_code_valid(w_d[i])) w_inv = 1'b1;
            if (w_d[i] != LAMP_RED)       w_nonred = w_nonred + 3'd1;
        end
    end

    assign w_multi    = (w_nonred > 3'd1);
    assign w_conflict = w_inv | w_multi;
    assign w_in_fault = (r_state == FAULT);

    flash_gen #(
        .HALF(FLASH_HALF)
    ) u_flash (
        .clk   (clk),
        .rst   (rst),
        .clear (!w_in_fault),
        .enable(w_in_fault),
        .phase (w_phase),
        .last  (w_last)
    );

    // Phase shown next cycle: flips when the half-period counter wraps.
    assign w_flash_lamp = (w_phase ^ w_last) ? LAMP_YEL : LAMP_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STARTUP;
            r_step  <= '0;
            r_deb   <= '0;
            r_lamp  <= {4{LAMP_RED}};
            r_fault <= 1'b0;
            r_fc    <= FC_NONE;
        end else begin
            case (r_state)
                STARTUP: begin
                    r_deb  <= '0;
                    r_lamp <= {4{LAMP_RED}};
                    if (r_step == c_step_last) begin
                        r_step  <= '0;
                        r_state <= PASS;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                PASS: begin
                    if (w_conflict) begin
                        r_lamp <= {4{LAMP_RED}};
                        if (r_deb == c_deb_last) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                            r_fc    <= w_inv ? FC_INV : FC_MULTI;
                            r_lamp  <= {4{LAMP_YEL}};
                        end
                        r_deb <= r_deb + 1'b1;
                    end else begin
                        r_deb  <= '0;
                        r_lamp <= w_d;
                    end
                end
                FAULT: begin
                    if (bus.fault_clear && !w_conflict) begin
                        r_state <= STARTUP;
                        r_step  <= '0;
                        r_deb   <= '0;
                        r_fault <= 1'b0;
                        r_fc    <= FC_NONE;
                        r_lamp  <= {4{LAMP_RED}};
                    end else begin
                        r_lamp <= {4{w_flash_lamp}};
                    end
                end
                default: begin
                    r_state <= STARTUP;
                    r_step  <= '0;
                    r_deb   <= '0;
                    r_lamp  <= {4{LAMP_RED}};
                end
            endcase
`ifdef TRAFFIC_LAMP_TEST_EN
            if (bus.lamp_test && (r_state != FAULT)) r_lamp <= {4{LAMP_ALL}};
`endif
        end
    end

    assign bus.lamp1      = r_lamp[0];
    assign bus.lamp2      = r_lamp[1];
    assign bus.lamp3      = r_lamp[2];
    assign bus.lamp4      = r_lamp[3];
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fc;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_conflict_monitor
// Description : Directed self-checking bench for traffic_conflict_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

    localparam int FH = 4;
    localparam int DB = 3;
    localparam int SC = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;

    traffic_conflict_monitor_if bus ();

    traffic_conflict_monitor #(
        .FLASH_HALF    (FH),
        .DEBOUNCE      (DB),
        .STARTUP_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: mode 0 startup, 1 pass, 2 fault; ages count elapsed cycles.
    int         m_mode;
    int         m_start_age;
    int         m_run;
    int         m_fault_age;
    logic [2:0] e_lamp [4];
    logic       e_fault;
    logic [1:0] e_fc;

    always @(posedge clk) begin : model
        logic [2:0] d [4];
        int         nonred;
        bit         inv;
        bit         conf;
        bit         lt;
        int         prev_mode;
        d = '{bus.d1_in, bus.d2_in, bus.d3_in, bus.d4_in};
`ifdef TRAFFIC_LAMP_TEST_EN
        lt = bus.lamp_test;
`else
        lt = 1'b0;
`endif
        nonred = 0;
        inv    = 1'b0;
        foreach (d[i]) begin
            if (d[i] != 3'b100) nonred++;
            if (!(d[i] inside {3'b100, 3'b010, 3'b001})) inv = 1'b1;
        end
        conf      = inv || (nonred > 1);
        prev_mode = m_mode;
        if (rst) begin
            m_mode = 0; m_start_age = 0; m_run = 0;
            e_lamp = '{4{3'b100}}; e_fault = 1'b0; e_fc = 2'b00;
        end else if (m_mode == 0) begin
            e_lamp = '{4{3'b100}};
            m_start_age++;
            m_run = 0;
            if (m_start_age == SC) m_mode = 1;
        end else if (m_mode == 1) begin
            if (conf) begin
                m_run++;
                e_lamp = '{4{3'b100}};
                if (m_run == DB) begin
                    m_mode = 2; m_fault_age = 0;
                    e_fault = 1'b1; e_fc = inv ? 2'b01 : 2'b10;
                    e_lamp = '{4{3'b010}};
                end
            end else begin
                m_run  = 0;
                e_lamp = d;
            end
        end else begin
            if (bus.fault_clear && !conf) begin
                m_mode = 0; m_start_age = 0; m_run = 0;
                e_fault = 1'b0; e_fc = 2'b00;
                e_lamp = '{4{3'b100}};
            end else begin
                m_fault_age++;
                e_lamp = '{4{((m_fault_age / FH) % 2 == 0) ? 3'b010 : 3'b000}};
            end
        end
        if (!rst && lt && prev_mode != 2) e_lamp = '{4{3'b111}};
    end

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model lamp1", bus.lamp1, e_lamp[0]);
            chk("model lamp2", bus.lamp2, e_lamp[1]);
            chk("model lamp3", bus.lamp3, e_lamp[2]);
            chk("model lamp4", bus.lamp4, e_lamp[3]);
            chk("model fault", {2'b00, bus.fault}, {2'b00, e_fault});
            chk("model fault_code", {1'b0, bus.fault_code}, {1'b0, e_fc});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_d(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] e);
        bus.d1_in = a; bus.d2_in = b; bus.d3_in = c; bus.d4_in = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fault_clear = 1'b0;
`ifdef TRAFFIC_LAMP_TEST_EN
        bus.lamp_test = 1'b0;
`endif
        set_d(3'b001, 3'b001, 3'b001, 3'b001);
        cyc(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset lamp1", bus.lamp1, 3'b100);
        chk("reset fault", {2'b00, bus.fault}, 3'b000);
        chk("reset code", {1'b0, bus.fault_code}, 3'b000);

        // Startup ignores the all-green conflict; first PASS cycle sees it.
        cyc(5); @(negedge clk);
        chk("startup end lamp4", bus.lamp4, 3'b100);
        cyc(2); @(negedge clk);
        chk("debouncing fault", {2'b00, bus.fault}, 3'b000);
        chk("debouncing lamp1", bus.lamp1, 3'b100);
        cyc(1); @(negedge clk);
        chk("multi fault", {2'b00, bus.fault}, 3'b001);
        chk("multi code", {1'b0, bus.fault_code}, 3'b010);
        chk("flash on first", bus.lamp1, 3'b010);
        cyc(4); @(negedge clk);
        chk("flash off", bus.lamp3, 3'b000);
        cyc(4); @(negedge clk);
        chk("flash on again", bus.lamp2, 3'b010);

        // Clear is ignored while the conflict persists.
        cyc(1);
        bus.fault_clear = 1'b1;
        cyc(2); @(negedge clk);
        chk("clear with conflict", {2'b00, bus.fault}, 3'b001);
        set_d(3'b001, 3'b100, 3'b100, 3'b100);
        cyc(1); @(negedge clk);
        chk("cleared fault", {2'b00, bus.fault}, 3'b000);
        chk("cleared code", {1'b0, bus.fault_code}, 3'b000);
        chk("cleared lamp1", bus.lamp1, 3'b100);
        bus.fault_clear = 1'b0;
        cyc(5); @(negedge clk);
        chk("restart last red", bus.lamp1, 3'b100);
        cyc(1); @(negedge clk);
        chk("pass green", bus.lamp1, 3'b001);

        set_d(3'b010, 3'b100, 3'b100, 3'b100);
        cyc(1); @(negedge clk);
        chk("pass yellow", bus.lamp1, 3'b010);
        set_d(3'b100, 3'b001, 3'b100, 3'b100);
        cyc(1); @(negedge clk);
        chk("pass lamp2 green", bus.lamp2, 3'b001);
        chk("pass lamp1 red", bus.lamp1, 3'b100);

        // Two-cycle glitch: safe hold, then pass-through resumes.
        set_d(3'b001, 3'b001, 3'b100, 3'b100);
        cyc(1); @(negedge clk);
        chk("glitch hold 1", bus.lamp1, 3'b100);
        cyc(1); @(negedge clk);
        chk("glitch hold 2", bus.lamp2, 3'b100);
        set_d(3'b001, 3'b100, 3'b100, 3'b100);
        cyc(1); @(negedge clk);
        chk("glitch resume", bus.lamp1, 3'b001);
        chk("glitch no fault", {2'b00, bus.fault}, 3'b000);

        // Invalid code latches FC_INV, which later conflicts do not overwrite.
        set_d(3'b100, 3'b100, 3'b000, 3'b100);
        cyc(1); @(negedge clk);
        chk("inv hold", bus.lamp3, 3'b100);
        cyc(2); @(negedge clk);
        chk("inv fault", {2'b00, bus.fault}, 3'b001);
        chk("inv code", {1'b0, bus.fault_code}, 3'b001);
        cyc(4); @(negedge clk);
        chk("inv flash off", bus.lamp1, 3'b000);
        set_d(3'b100, 3'b001, 3'b011, 3'b100);
        cyc(1); @(negedge clk);
        chk("code held", {1'b0, bus.fault_code}, 3'b001);
        chk("still off", bus.lamp4, 3'b000);

        // Reset on a flash-off cycle.
        rst = 1'b1;
        cyc(1); @(negedge clk);
        chk("mid-fault reset lamp", bus.lamp2, 3'b100);
        chk("mid-fault reset fault", {2'b00, bus.fault}, 3'b000);
        rst = 1'b0;
        set_d(3'b100, 3'b100, 3'b001, 3'b100);
        cyc(5); @(negedge clk);
        chk("post-reset startup", bus.lamp3, 3'b100);
        cyc(1); @(negedge clk);
        chk("post-reset pass", bus.lamp3, 3'b001);
`ifdef TRAFFIC_LAMP_TEST_EN
        bus.lamp_test = 1'b1;
        cyc(1); @(negedge clk);
        chk("lamp test", bus.lamp1, 3'b111);
        bus.lamp_test = 1'b0;
        cyc(1); @(negedge clk);
        chk("lamp test off", bus.lamp3, 3'b001);
`endif
        cyc(2); @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Downstream stage of the four-approach traffic light controller. It consumes the four 3-bit lamp codes and drives the physical lamp outputs.
- Registers and passes lamp codes through while they are safe. Detects invalid codes and conflicting non-red approaches.
- On a persistent conflict, latches a fault and forces all approaches to flashing yellow until a deliberate clear.
- Provides a defined all-red startup interval after reset and after a fault clear.

Parameters:
- FLASH_HALF, default 25000000: cycles per flash half-period (on or off).
- DEBOUNCE, default 4: consecutive conflict cycles required to latch a fault (min 1).
- STARTUP_CYCLES, default 50000000: all-red hold after reset or fault clear (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d1_in  in  3  approach 1 code from controller: 100 red, 010 yellow, 001 green
- d2_in  in  3  approach 2 code
- d3_in  in  3  approach 3 code
- d4_in  in  3  approach 4 code
- fault_clear  in  1  level; request to leave the fault state
- lamp1  out  3  approach 1 lamp drive, same encoding
- lamp2  out  3  approach 2 lamp drive
- lamp3  out  3  approach 3 lamp drive
- lamp4  out  3  approach 4 lamp drive
- fault  out  1  high while in FAULT
- fault_code  out  2  00 none, 01 invalid code, 10 multiple non-red

Behaviour:
- Reset is synchronous, active-high, single clock clk. On reset: state=STARTUP, lamps=100 on all approaches, fault=0, fault_code=00, all counters cleared.
- All outputs are registered. Lamp latency is 1 cycle from d*_in to lamp*.
- Per-cycle conflict detection is combinational:
  - inv: any d*_in not in {100, 010, 001}; includes 000 and 111.
  - multi: more than one approach is not 100.
  - conflict = inv OR multi.
- Debounce counter:
  - increments on each conflict cycle, saturating at DEBOUNCE.
  - clears on any non-conflict cycle.
- STARTUP:
  - lamps=100 all; the step counter counts to STARTUP_CYCLES-1, then the state goes to PASS.
  - conflicts are ignored; the debounce counter is held at 0.
- PASS:
  - If there is no conflict: lamps = d*_in, 1 cycle late.
  - If there is a conflict this cycle: lamps=100 all on the next cycle (safe hold), even before the debounce count is reached.
  - When the debounce count reaches DEBOUNCE (the DEBOUNCE-th consecutive conflict cycle): next state=FAULT, fault=1, fault_code latched from that cycle.
  - If inv and multi are both true, inv wins (fault_code=01).
- FAULT:
  - lamps alternate 010 all (phase on) and 000 all (phase off), each phase FLASH_HALF cycles.
  - The first FAULT cycle starts the on-phase with the flash counter at 0.
  - fault_code is held; a new conflict type does not overwrite it.
  - If fault_clear=1 AND conflict=0 in the same cycle: next state=STARTUP, fault=0, fault_code=00. The flash counter and step counter clear.
  - fault_clear while a conflict is present is ignored.
- fault_clear in STARTUP or PASS has no effect.
- Reset asserted mid-FAULT or mid-STARTUP: immediate reset values on the next edge; the fault is not retained.
- Counter widths: $clog2(max(param)+1). No wrap: counters reset at their terminal value.

Optional Feature:
- Macro: TRAFFIC_LAMP_TEST_EN.
- When defined:
  - adds input lamp_test (1 bit).
  - In PASS or STARTUP, lamp_test=1 drives lamps=111 all on the next cycle. Detection and counters continue unaffected.
  - lamp_test is ignored in FAULT.
- When undefined: no lamp_test port; behaviour as above.

Decomposition:
- Package traffic_pkg holds:
  - lamp code constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000, LAMP_ALL=3'b111.
  - state encoding STARTUP/PASS/FAULT.
  - fault code constants FC_NONE/FC_INV/FC_MULTI.
- One sub-module, flash_gen:
  - parameterised half-period counter with synchronous clear and enable.
  - outputs the phase bit.
  - instantiated once for the FAULT flash.

Test Plan:
- Parameters for the bench: FLASH_HALF=4, DEBOUNCE=3, STARTUP_CYCLES=5.
- Reset, all inputs 001 -> lamps=100 all for 5 cycles, then PASS. Conflict is ignored during STARTUP, but multi is seen on the first PASS cycle -> lamps stay 100, and FAULT (code 10) after 3 conflict cycles.
- Normal sequence: d1=001, others 100 -> lamp1=001 one cycle later. Then d1=010 -> lamp1=010 next cycle. Then d2=001 with d1=100 -> lamp2=001; fault stays 0.
- Glitch in PASS: d1=001, d2=001 for 2 cycles, then d2=100 -> lamps=100 all for 2 cycles, then pass-through resumes; fault=0.
- Invalid code: d3=000 for 3 cycles -> fault=1, fault_code=01. Lamps alternate 010 x4 / 000 x4 cycles. Then d3=011 as well as d2=001 -> fault_code remains 01.
- Clear rules:
  - fault_clear=1 with conflict present -> remains FAULT.
  - fault_clear=1 with valid single-green inputs -> STARTUP: lamps 100 for 5 cycles, fault=0, fault_code=00, then PASS.
- Reset mid-FAULT on a flash-off cycle -> next cycle lamps=100, fault=0, STARTUP restarts. With TRAFFIC_LAMP_TEST_EN, lamp_test=1 in PASS -> lamps=111 next cycle.
